// File: rtl/peak_frame_averager_if.sv
// Frame-result bus between the two-peak finder, the frame averager and the readout logic.
// The slave modport is the averager's view; the master modport is the producer/consumer side.
interface peak_frame_averager_if #(
  parameter int VALUE_WIDTH = 32,
  parameter int INDEX_WIDTH = 11
);
  logic                   last_in;
  logic [VALUE_WIDTH-1:0] peak1_i;
  logic [VALUE_WIDTH-1:0] peak2_i;
  logic [INDEX_WIDTH-1:0] index1_i;
  logic [INDEX_WIDTH-1:0] index2_i;
  logic                   out_valid;
  logic                   out_ready;
  logic [VALUE_WIDTH-1:0] avg1_o;
  logic [VALUE_WIDTH-1:0] avg2_o;
  logic [INDEX_WIDTH-1:0] index1_o;
  logic [INDEX_WIDTH-1:0] index2_o;
  logic                   stable1_o;
  logic                   stable2_o;
  logic                   overrun_o;

  modport slave (
    input  last_in, peak1_i, peak2_i, index1_i, index2_i, out_ready,
    output out_valid, avg1_o, avg2_o, index1_o, index2_o, stable1_o, stable2_o, overrun_o
  );

  modport master (
    output last_in, peak1_i, peak2_i, index1_i, index2_i, out_ready,
    input  out_valid, avg1_o, avg2_o, index1_o, index2_o, stable1_o, stable2_o, overrun_o
  );
endinterface

// File: rtl/peak_frame_averager.sv
// Averages peak1/peak2 over 2^LOG2_FRAMES frames and tracks index stability per batch.
// The result sits in a valid/ready holding register; accumulation never stalls.
module peak_frame_averager #(
  parameter int VALUE_WIDTH = 32,
  parameter int INDEX_WIDTH = 11,
  parameter int LOG2_FRAMES = 2,
  parameter int IDX_TOL     = 2
) (
  input logic                  clk,
  input logic                  aresetn,
  peak_frame_averager_if.slave bus
);
  localparam int AW = VALUE_WIDTH + LOG2_FRAMES;
  localparam int CW = (LOG2_FRAMES > 0) ? LOG2_FRAMES : 1;
  localparam int N  = 1 << LOG2_FRAMES;

  function automatic logic [INDEX_WIDTH-1:0] abs_diff(input logic [INDEX_WIDTH-1:0] a,
                                                      input logic [INDEX_WIDTH-1:0] b);
    if (a >= b) abs_diff = a - b;
    else        abs_diff = b - a;
  endfunction

  logic [CW-1:0]          count_q, count_d;
  logic [AW-1:0]          acc1_q, acc1_d, acc2_q, acc2_d;
  logic [INDEX_WIDTH-1:0] ref1_q, ref1_d, ref2_q, ref2_d;
  logic                   stab1_q, stab1_d, stab2_q, stab2_d;
  logic                   valid_q, valid_d, overrun_q, overrun_d;
  logic [VALUE_WIDTH-1:0] avg1_q, avg1_d, avg2_q, avg2_d;
  logic [INDEX_WIDTH-1:0] idx1_q, idx1_d, idx2_q, idx2_d;
  logic                   st1_q, st1_d, st2_q, st2_d;

  logic                   first_s, last_frame_s, complete_s;
  logic [AW-1:0]          sum1_s, sum2_s;
  logic [INDEX_WIDTH-1:0] ref1_s, ref2_s;
  logic                   stab1_s, stab2_s;

  // Frame-T view: sums, reference indices and stability including the current frame.
  always_comb begin
    first_s      = (count_q == {CW{1'b0}});
    last_frame_s = (LOG2_FRAMES == 0) ? 1'b1 : (count_q == CW'(N - 1));
    complete_s   = bus.last_in && last_frame_s;
    if (first_s) begin
      sum1_s  = AW'(bus.peak1_i);
      sum2_s  = AW'(bus.peak2_i);
      ref1_s  = bus.index1_i;
      ref2_s  = bus.index2_i;
      stab1_s = 1'b1;
      stab2_s = 1'b1;
    end else begin
      sum1_s  = acc1_q + AW'(bus.peak1_i);
      sum2_s  = acc2_q + AW'(bus.peak2_i);
      ref1_s  = ref1_q;
      ref2_s  = ref2_q;
      stab1_s = stab1_q && (abs_diff(bus.index1_i, ref1_q) <= INDEX_WIDTH'(IDX_TOL));
      stab2_s = stab2_q && (abs_diff(bus.index2_i, ref2_q) <= INDEX_WIDTH'(IDX_TOL));
    end
  end

  // Next-state for the accumulator and the output holding register.
  always_comb begin
    count_d   = count_q;
    acc1_d    = acc1_q;
    acc2_d    = acc2_q;
    ref1_d    = ref1_q;
    ref2_d    = ref2_q;
    stab1_d   = stab1_q;
    stab2_d   = stab2_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    avg1_d    = avg1_q;
    avg2_d    = avg2_q;
    idx1_d    = idx1_q;
    idx2_d    = idx2_q;
    st1_d     = st1_q;
    st2_d     = st2_q;
    if (bus.last_in) begin
      count_d = last_frame_s ? {CW{1'b0}} : count_q + CW'(1);
      acc1_d  = sum1_s;
      acc2_d  = sum2_s;
      ref1_d  = ref1_s;
      ref2_d  = ref2_s;
      stab1_d = stab1_s;
      stab2_d = stab2_s;
    end else begin
      count_d = count_q;
    end
    // A held result with no taker blocks the new one; the new one is lost.
    if (complete_s && (!valid_q || bus.out_ready)) begin
      valid_d = 1'b1;
      avg1_d  = VALUE_WIDTH'(sum1_s >> LOG2_FRAMES);
      avg2_d  = VALUE_WIDTH'(sum2_s >> LOG2_FRAMES);
      idx1_d  = ref1_s;
      idx2_d  = ref2_s;
      st1_d   = stab1_s;
      st2_d   = stab2_s;
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (complete_s && valid_q && !bus.out_ready) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      count_q   <= {CW{1'b0}};
      acc1_q    <= {AW{1'b0}};
      acc2_q    <= {AW{1'b0}};
      ref1_q    <= {INDEX_WIDTH{1'b0}};
      ref2_q    <= {INDEX_WIDTH{1'b0}};
      stab1_q   <= 1'b1;
      stab2_q   <= 1'b1;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      avg1_q    <= {VALUE_WIDTH{1'b0}};
      avg2_q    <= {VALUE_WIDTH{1'b0}};
      idx1_q    <= {INDEX_WIDTH{1'b0}};
      idx2_q    <= {INDEX_WIDTH{1'b0}};
      st1_q     <= 1'b0;
      st2_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      acc1_q    <= acc1_d;
      acc2_q    <= acc2_d;
      ref1_q    <= ref1_d;
      ref2_q    <= ref2_d;
      stab1_q   <= stab1_d;
      stab2_q   <= stab2_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      avg1_q    <= avg1_d;
      avg2_q    <= avg2_d;
      idx1_q    <= idx1_d;
      idx2_q    <= idx2_d;
      st1_q     <= st1_d;
      st2_q     <= st2_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.avg1_o    = avg1_q;
  assign bus.avg2_o    = avg2_q;
  assign bus.index1_o  = idx1_q;
  assign bus.index2_o  = idx2_q;
  assign bus.stable1_o = st1_q;
  assign bus.stable2_o = st2_q;
  assign bus.overrun_o = overrun_q;
endmodule

// File: tb/tb_peak_frame_averager.sv
// Directed bench for peak_frame_averager: inputs change and outputs are sampled on the falling edge.
module tb_peak_frame_averager;
  logic clk;
  logic aresetn;
  int   checks_cnt;
  int   fail_cnt;

  peak_frame_averager_if #(.VALUE_WIDTH(32), .INDEX_WIDTH(11)) bus ();

  peak_frame_averager #(
    .VALUE_WIDTH(32), .INDEX_WIDTH(11), .LOG2_FRAMES(2), .IDX_TOL(2)
  ) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt = checks_cnt + 1;
    if (obs !== exp) begin
      fail_cnt = fail_cnt + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One last_in pulse; returns on the falling edge right after the capturing rising edge.
  task automatic frame(input logic [31:0] p1, input logic [31:0] p2,
                       input logic [10:0] i1, input logic [10:0] i2, input logic rdy);
    @(negedge clk);
    bus.last_in   = 1'b1;
    bus.peak1_i   = p1;
    bus.peak2_i   = p2;
    bus.index1_i  = i1;
    bus.index2_i  = i2;
    bus.out_ready = rdy;
    @(negedge clk);
    bus.last_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    aresetn = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
  endtask

  initial begin
    checks_cnt    = 0;
    fail_cnt      = 0;
    aresetn       = 1'b0;
    bus.last_in   = 1'b0;
    bus.peak1_i   = 32'd0;
    bus.peak2_i   = 32'd0;
    bus.index1_i  = 11'd0;
    bus.index2_i  = 11'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    check_eq("rst_avg1", {32'd0, bus.avg1_o}, 64'd0);
    check_eq("rst_overrun", {63'd0, bus.overrun_o}, 64'd0);
    aresetn = 1'b1;

    // Scenario 1: basic average, indices within tolerance
    frame(32'd100, 32'd10, 11'd10, 11'd50, 1'b1);
    frame(32'd200, 32'd20, 11'd11, 11'd50, 1'b1);
    frame(32'd300, 32'd30, 11'd9,  11'd50, 1'b1);
    check_eq("s1_not_yet", {63'd0, bus.out_valid}, 64'd0);
    frame(32'd401, 32'd40, 11'd12, 11'd50, 1'b1);
    check_eq("s1_valid", {63'd0, bus.out_valid}, 64'd1);
    check_eq("s1_avg1", {32'd0, bus.avg1_o}, 64'd250);
    check_eq("s1_avg2", {32'd0, bus.avg2_o}, 64'd25);
    check_eq("s1_idx1", {53'd0, bus.index1_o}, 64'd10);
    check_eq("s1_idx2", {53'd0, bus.index2_o}, 64'd50);
    check_eq("s1_stable1", {63'd0, bus.stable1_o}, 64'd1);
    check_eq("s1_stable2", {63'd0, bus.stable2_o}, 64'd1);
    @(negedge clk);
    check_eq("s1_valid_drop", {63'd0, bus.out_valid}, 64'd0);
    check_eq("s1_avg1_kept", {32'd0, bus.avg1_o}, 64'd250);

    // Scenario 2: index1 out of tolerance, then tracker re-armed
    frame(32'd100, 32'd10, 11'd10, 11'd50, 1'b1);
    frame(32'd200, 32'd20, 11'd11, 11'd50, 1'b1);
    frame(32'd300, 32'd30, 11'd9,  11'd50, 1'b1);
    frame(32'd401, 32'd40, 11'd13, 11'd50, 1'b1);
    check_eq("s2_avg1", {32'd0, bus.avg1_o}, 64'd250);
    check_eq("s2_stable1", {63'd0, bus.stable1_o}, 64'd0);
    check_eq("s2_stable2", {63'd0, bus.stable2_o}, 64'd1);
    for (int k = 0; k < 4; k++) frame(32'd4, 32'd6, 11'd5, 11'd7, 1'b1);
    check_eq("s2b_avg1", {32'd0, bus.avg1_o}, 64'd4);
    check_eq("s2b_idx1", {53'd0, bus.index1_o}, 64'd5);
    check_eq("s2b_stable1", {63'd0, bus.stable1_o}, 64'd1);

    // Scenario 3: consumer stalls through two batches
    for (int k = 0; k < 4; k++) frame(32'd40, 32'd4, 11'd7, 11'd8, 1'b0);
    check_eq("s3_valid_a", {63'd0, bus.out_valid}, 64'd1);
    check_eq("s3_avg1_a", {32'd0, bus.avg1_o}, 64'd40);
    check_eq("s3_overrun_a", {63'd0, bus.overrun_o}, 64'd0);
    for (int k = 0; k < 4; k++) frame(32'd80, 32'd8, 11'd3, 11'd4, 1'b0);
    check_eq("s3_avg1_held", {32'd0, bus.avg1_o}, 64'd40);
    check_eq("s3_idx1_held", {53'd0, bus.index1_o}, 64'd7);
    check_eq("s3_overrun_b", {63'd0, bus.overrun_o}, 64'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("s3_valid_done", {63'd0, bus.out_valid}, 64'd0);
    check_eq("s3_overrun_sticky", {63'd0, bus.overrun_o}, 64'd1);
    check_eq("s3_avg1_kept", {32'd0, bus.avg1_o}, 64'd40);

    // Scenario 4: ready arrives exactly in the completion cycle of the next batch
    do_reset();
    check_eq("s4_overrun_clr", {63'd0, bus.overrun_o}, 64'd0);
    for (int k = 0; k < 4; k++) frame(32'd12, 32'd2, 11'd1, 11'd2, 1'b0);
    for (int k = 0; k < 3; k++) frame(32'd20, 32'd3, 11'd1, 11'd2, 1'b0);
    check_eq("s4_valid_held", {63'd0, bus.out_valid}, 64'd1);
    check_eq("s4_avg1_held", {32'd0, bus.avg1_o}, 64'd12);
    frame(32'd20, 32'd3, 11'd1, 11'd2, 1'b1);
    check_eq("s4_valid_cont", {63'd0, bus.out_valid}, 64'd1);
    check_eq("s4_avg1_new", {32'd0, bus.avg1_o}, 64'd20);
    check_eq("s4_overrun", {63'd0, bus.overrun_o}, 64'd0);
    @(negedge clk);
    check_eq("s4_valid_drop", {63'd0, bus.out_valid}, 64'd0);

    // Scenario 5: full-scale peaks do not wrap
    for (int k = 0; k < 4; k++) frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 11'd0, 11'd0, 1'b1);
    check_eq("s5_avg1", {32'd0, bus.avg1_o}, 64'hFFFF_FFFF);
    check_eq("s5_avg2", {32'd0, bus.avg2_o}, 64'hFFFF_FFFF);

    // Scenario 6: reset mid-batch discards the partial batch; last_in during reset ignored
    frame(32'd1000, 32'd1000, 11'd0, 11'd0, 1'b1);
    frame(32'd1000, 32'd1000, 11'd0, 11'd0, 1'b1);
    @(negedge clk);
    aresetn      = 1'b0;
    bus.last_in  = 1'b1;
    bus.peak1_i  = 32'd1000;
    @(negedge clk);
    bus.last_in = 1'b0;
    check_eq("s6_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    check_eq("s6_rst_avg1", {32'd0, bus.avg1_o}, 64'd0);
    check_eq("s6_rst_stable1", {63'd0, bus.stable1_o}, 64'd0);
    aresetn = 1'b1;
    for (int k = 0; k < 3; k++) frame(32'd8, 32'd2, 11'd9, 11'd9, 1'b1);
    check_eq("s6_not_yet", {63'd0, bus.out_valid}, 64'd0);
    frame(32'd8, 32'd2, 11'd9, 11'd9, 1'b1);
    check_eq("s6_valid", {63'd0, bus.out_valid}, 64'd1);
    check_eq("s6_avg1", {32'd0, bus.avg1_o}, 64'd8);
    check_eq("s6_avg2", {32'd0, bus.avg2_o}, 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end
endmodule

// File: doc/peak_frame_averager.md
Name: peak_frame_averager

Overview:
Downstream consumer of the two-peak finder stage. Captures peak1/peak2 values and indices on each end-of-frame pulse (the finder's last_out), accumulates over 2^LOG2_FRAMES frames, and emits truncated averages plus per-peak index-stability flags through a valid/ready output register. Result is consumed by the register/readout logic.

Parameters:
VALUE_WIDTH, 32, width of peak values (matches the `VALUE_WIDTH` constant)
INDEX_WIDTH, 11, width of peak indices
LOG2_FRAMES, 2, log2 of frames per average (N = 2^LOG2_FRAMES, range 0..8)
IDX_TOL, 2, maximum |index - first-frame index| still counted as stable

Ports:
clk  in  1  clock
aresetn  in  1  synchronous active-low reset
last_in  in  1  one-cycle frame-complete strobe, from the peak stage's last_out
peak1_i  in  VALUE_WIDTH  largest peak of the frame, sampled when last_in=1
peak2_i  in  VALUE_WIDTH  second peak, sampled when last_in=1
index1_i  in  INDEX_WIDTH  index of peak1, sampled when last_in=1
index2_i  in  INDEX_WIDTH  index of peak2, sampled when last_in=1
out_valid  out  1  averaged result available
out_ready  in  1  consumer accepts the result
avg1_o  out  VALUE_WIDTH  average of peak1 over N frames
avg2_o  out  VALUE_WIDTH  average of peak2 over N frames
index1_o  out  INDEX_WIDTH  first-frame index1 of the batch
index2_o  out  INDEX_WIDTH  first-frame index2 of the batch
stable1_o  out  1  every index1 in the batch is within IDX_TOL of the first
stable2_o  out  1  same for index2
overrun_o  out  1  sticky: a completed batch was dropped

Behaviour:
- Reset (aresetn=0 at a posedge): all outputs 0, frame count 0, accumulators 0, stability trackers 1. Reset has priority over every event, including mid-batch; a partial batch is discarded.
- Accumulators are VALUE_WIDTH+LOG2_FRAMES bits wide with no overflow possible. Inputs are unsigned.
- Internal states are ACC (count 0..N-1) and an output holding register. Accumulation never stalls, so the next batch starts while a result is still held.
- On last_in with count=0:
  - acc1/acc2 are loaded with the peaks.
  - ref1/ref2 are loaded with the indices.
  - stable1/2 are set to 1.
- On last_in with count>0:
  - acc += peak.
  - stableX is cleared if |indexX_i - refX| > IDX_TOL, computed as an unsigned absolute difference with no wrap.
- count increments modulo N.
- Batch completion happens on the last_in where count=N-1, at cycle T.
  - Final sum = acc + peak, combinational in T.
  - avg = sum >> LOG2_FRAMES, truncated.
  - Stability includes the frame-T index check.
  - When loaded, the result appears on the outputs with out_valid=1 at T+1.
- Output handshake:
  - A transfer occurs when out_valid && out_ready at a posedge.
  - Outputs are held stable while out_valid && !out_ready.
  - After a transfer with no new result, out_valid returns to 0 and data outputs keep their last values.
- Simultaneous events at T:
  - out_valid=0, or out_valid=1 with out_ready=1: the new result loads and out_valid=1 at T+1, with no gap.
  - out_valid=1 with out_ready=0: the new result is dropped, the held result is unchanged, and overrun_o=1 from T+1 until reset.
- LOG2_FRAMES=0: every last_in completes a batch. avg equals the input, stable flags are 1 and index outputs equal the inputs.
- last_in while aresetn=0 is ignored. last_in is never high on consecutive cycles (upstream guarantee). Behaviour is still defined if it is: each pulse counts as a frame.

Test Plan:
1. LOG2_FRAMES=2, IDX_TOL=2. Four last_in pulses with peak1=100,200,300,401, peak2=10,20,30,40, index1=10,11,9,12, index2=50,50,50,50, out_ready=1. Expect, one cycle after the 4th pulse: avg1_o=250, avg2_o=25, index1_o=10, index2_o=50, stable1_o=1, stable2_o=1, out_valid high for exactly 1 cycle.
2. Same as scenario 1 but the 4th index1=13. Expect stable1_o=0 and stable2_o=1. Next batch with constant indices gives stable1_o=1 (tracker re-armed).
3. out_ready=0 held through two full batches. Expect the first batch's values to stay on the outputs, overrun_o=1 one cycle after the 2nd batch completes, and overrun stays 1 after out_ready=1.
4. out_ready=1 exactly in the cycle the 2nd batch completes while the 1st is held. Expect the 1st transferred, the 2nd on the outputs at T+1, out_valid continuously 1, overrun_o=0.
5. Peaks all 0xFFFFFFFF for 4 frames. Expect avg1_o=0xFFFFFFFF with no wrap.
6. Two frames into a batch, pulse aresetn=0 for 1 cycle, then 4 frames of peak1=8. Expect avg1_o=8 (the partial batch is discarded), and all outputs 0 during reset.
